// File: rtl/nav_pkg.sv
// Shared encodings and arithmetic helpers for the navigation localization slice.
package nav_pkg;

  localparam int unsigned CALC_W = 16;

  localparam logic [1:0] ORI_N = 2'd0;
  localparam logic [1:0] ORI_E = 2'd1;
  localparam logic [1:0] ORI_S = 2'd2;
  localparam logic [1:0] ORI_W = 2'd3;

  localparam logic [2:0] SEC_A = 3'd1;
  localparam logic [2:0] SEC_B = 3'd2;
  localparam logic [2:0] SEC_C = 3'd3;
  localparam logic [2:0] SEC_D = 3'd4;
  localparam logic [2:0] SEC_E = 3'd5;
  localparam logic [2:0] SEC_F = 3'd6;
  localparam logic [2:0] SEC_G = 3'd7;

  localparam logic [4:0] CMD_TURN_RIGHT = 5'b01100;
  localparam logic [4:0] CMD_TURN_LEFT  = 5'b00110;
  localparam logic [4:0] CMD_STRAIGHT   = 5'b01110;

  // Subtract that floors at zero instead of wrapping.
  function automatic logic [CALC_W-1:0] sat0(input logic [CALC_W-1:0] a,
                                             input logic [CALC_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/tilt_debouncer.sv
// Accepts a tilt-switch change only after it has been stable for TILT_DEBOUNCE cycles.
module tilt_debouncer #(
  parameter int unsigned TILT_DEBOUNCE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic TILT_RAW,
  output logic tilt_q,
  output logic tilt_rise,
  output logic tilt_fall
);

  localparam int unsigned CW = $clog2(TILT_DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(TILT_DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      tilt_q    <= 1'b0;
      tilt_rise <= 1'b0;
      tilt_fall <= 1'b0;
    end else begin
      tilt_rise <= 1'b0;
      tilt_fall <= 1'b0;
      if (TILT_RAW != tilt_q) begin
        if (cnt == LAST) begin
          tilt_q    <= TILT_RAW;
          tilt_rise <= TILT_RAW;
          tilt_fall <= ~TILT_RAW;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/nav_localizer.sv
// Heading tracker, course-sector FSM, wall-distance and cargo-zone localization.
module nav_localizer
  import nav_pkg::*;
#(
  parameter int unsigned DIST_W         = 8,
  parameter int unsigned ROBOT_W_2_E    = 26,
  parameter int unsigned ROBOT_N_2_S    = 28,
  parameter int unsigned SECTOR_B_DELTA = 57,
  parameter int unsigned CARGO_COVERAGE = 108,
  parameter int unsigned ZONE_SEP       = 8,
  parameter int unsigned ZONE_OFFSET    = 4,
  parameter int unsigned NUM_ZONES      = 14,
  parameter int unsigned TILT_DEBOUNCE  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CAL_VALID,
  input  logic [DIST_W-1:0] INITIAL_X,
  input  logic [DIST_W-1:0] INITIAL_Y,
  input  logic [4:0]        COMMAND,
  input  logic [DIST_W-1:0] DISTANCE_FRONT,
  input  logic [DIST_W-1:0] DISTANCE_SIDE_FRONT,
  input  logic              TILT_RAW,
  output logic              CALIBRATED,
  output logic [1:0]        ORIENTATION,
  output logic [2:0]        SECTOR,
  output logic [DIST_W-1:0] BACK_DISTANCE,
  output logic [DIST_W-1:0] RIGHT_DISTANCE,
  output logic [3:0]        ZONE_INDEX,
  output logic              ZONE_HIT
);

  localparam int unsigned GW = DIST_W + 1;
  localparam logic [CALC_W-1:0] DIST_MAX = CALC_W'((2 ** DIST_W) - 1);

  logic [GW-1:0]     course_we, course_ns, half_we, zone_base;
  logic [GW-1:0]     cal_we, cal_ns;
  logic [4:0]        old_command;
  logic [2:0]        sector_next;
  logic [3:0]        zone_next;
  logic              tilt_rise, tilt_fall, tilt_q_unused;
  logic [CALC_W-1:0] front_c, side_c, we_c, ns_c, half_c, base_c;
  logic [CALC_W-1:0] span_ns, along, across, back_c, right_c, zone_z, zone_d;

  assign front_c = CALC_W'(DISTANCE_FRONT);
  assign side_c  = CALC_W'(DISTANCE_SIDE_FRONT);
  assign we_c    = CALC_W'(course_we);
  assign ns_c    = CALC_W'(course_ns);
  assign half_c  = CALC_W'(half_we);
  assign base_c  = CALC_W'(zone_base);
  assign cal_we  = GW'(INITIAL_X) + GW'(ROBOT_W_2_E);
  assign cal_ns  = GW'(INITIAL_Y) + GW'(ROBOT_N_2_S);

  tilt_debouncer #(.TILT_DEBOUNCE(TILT_DEBOUNCE)) u_tilt (
    .CLK       (CLK),
    .RST       (RST),
    .TILT_RAW  (TILT_RAW),
    .tilt_q    (tilt_q_unused),
    .tilt_rise (tilt_rise),
    .tilt_fall (tilt_fall)
  );

  // Re-calibration only refreshes geometry; sector and heading keep running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      course_we  <= '0;
      course_ns  <= '0;
      half_we    <= '0;
      zone_base  <= '0;
      CALIBRATED <= 1'b0;
    end else if (CAL_VALID) begin
      course_we  <= cal_we;
      course_ns  <= cal_ns;
      half_we    <= cal_we >> 1;
      zone_base  <= GW'(sat0(sat0(CALC_W'(cal_ns), CALC_W'(SECTOR_B_DELTA)),
                             CALC_W'(CARGO_COVERAGE)) >> 1);
      CALIBRATED <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ORIENTATION <= ORI_N;
      old_command <= CMD_STRAIGHT;
    end else begin
      old_command <= COMMAND;
      if (COMMAND != old_command) begin
        if (old_command == CMD_TURN_LEFT)
          ORIENTATION <= ORIENTATION - 2'd1;
        else if (old_command == CMD_TURN_RIGHT)
          ORIENTATION <= ORIENTATION + 2'd1;
      end
    end
  end

  always_comb begin
    sector_next = SECTOR;
    case (SECTOR)
      SEC_A: if (ORIENTATION == ORI_W && front_c <= half_c) sector_next = SEC_B;
             else if (ORIENTATION == ORI_N && front_c <= half_c) sector_next = SEC_C;
      SEC_B: if (ORIENTATION == ORI_E && front_c <= half_c) sector_next = SEC_A;
      SEC_C: if (ORIENTATION == ORI_W && tilt_rise) sector_next = SEC_D;
             else if (ORIENTATION == ORI_S && front_c <= sat0(ns_c, half_c)) sector_next = SEC_A;
      SEC_D: if (ORIENTATION == ORI_W && tilt_fall) sector_next = SEC_E;
             else if (ORIENTATION == ORI_E && tilt_fall) sector_next = SEC_C;
      SEC_E: if (ORIENTATION == ORI_S && tilt_rise) sector_next = SEC_F;
             else if (ORIENTATION == ORI_E && tilt_rise) sector_next = SEC_D;
      SEC_F: if (ORIENTATION == ORI_S && tilt_fall) sector_next = SEC_G;
             else if (ORIENTATION == ORI_N && tilt_fall) sector_next = SEC_E;
      SEC_G: if (ORIENTATION == ORI_N && tilt_rise) sector_next = SEC_F;
      default: sector_next = SEC_A;
    endcase
  end

  // E and W both have bit 0 set: the course axes swap when facing them.
  always_comb begin
    span_ns = (SECTOR == SEC_B) ? sat0(ns_c, CALC_W'(SECTOR_B_DELTA)) : ns_c;
    along   = ORIENTATION[0] ? we_c : span_ns;
    across  = ORIENTATION[0] ? span_ns : we_c;
    back_c  = sat0(sat0(along, CALC_W'(ROBOT_N_2_S)), front_c);
    right_c = sat0(sat0(across, CALC_W'(ROBOT_W_2_E)), side_c);
    if (back_c > DIST_MAX) back_c = DIST_MAX;
    if (right_c > DIST_MAX) right_c = DIST_MAX;
  end

  // Scan from the far zone down so the lowest matching index wins.
  always_comb begin
    zone_next = '0;
    zone_z    = '0;
    zone_d    = '0;
    if (SECTOR == SEC_B) begin
      for (int unsigned k = NUM_ZONES; k >= 1; k--) begin
        zone_z = base_c + CALC_W'(ZONE_OFFSET) + CALC_W'((NUM_ZONES - k) * ZONE_SEP);
        zone_d = (front_c > zone_z) ? (front_c - zone_z) : (zone_z - front_c);
        if (zone_d < CALC_W'(ZONE_SEP / 2)) zone_next = 4'(k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || !CALIBRATED) begin
      SECTOR         <= SEC_A;
      BACK_DISTANCE  <= '0;
      RIGHT_DISTANCE <= '0;
      ZONE_INDEX     <= '0;
      ZONE_HIT       <= 1'b0;
    end else begin
      SECTOR         <= sector_next;
      BACK_DISTANCE  <= DIST_W'(back_c);
      RIGHT_DISTANCE <= DIST_W'(right_c);
      ZONE_INDEX     <= zone_next;
      ZONE_HIT       <= (zone_next != '0) && (zone_next != ZONE_INDEX);
    end
  end

endmodule

// File: tb/tb_nav_localizer.sv
// Directed self-checking bench for nav_localizer with default geometry parameters.
module tb_nav_localizer;

  logic       CLK = 1'b0;
  logic       RST, CAL_VALID, TILT_RAW;
  logic [7:0] INITIAL_X, INITIAL_Y, DISTANCE_FRONT, DISTANCE_SIDE_FRONT;
  logic [4:0] COMMAND;
  logic       CALIBRATED, ZONE_HIT;
  logic [1:0] ORIENTATION;
  logic [2:0] SECTOR;
  logic [7:0] BACK_DISTANCE, RIGHT_DISTANCE;
  logic [3:0] ZONE_INDEX;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] RIGHT = 5'b01100;
  localparam logic [4:0] LEFT  = 5'b00110;
  localparam logic [4:0] STR   = 5'b01110;

  always #5 CLK = ~CLK;

  nav_localizer dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .CAL_VALID           (CAL_VALID),
    .INITIAL_X           (INITIAL_X),
    .INITIAL_Y           (INITIAL_Y),
    .COMMAND             (COMMAND),
    .DISTANCE_FRONT      (DISTANCE_FRONT),
    .DISTANCE_SIDE_FRONT (DISTANCE_SIDE_FRONT),
    .TILT_RAW            (TILT_RAW),
    .CALIBRATED          (CALIBRATED),
    .ORIENTATION         (ORIENTATION),
    .SECTOR              (SECTOR),
    .BACK_DISTANCE       (BACK_DISTANCE),
    .RIGHT_DISTANCE      (RIGHT_DISTANCE),
    .ZONE_INDEX          (ZONE_INDEX),
    .ZONE_HIT            (ZONE_HIT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic turn(input logic [4:0] cmd);
    COMMAND = cmd;
    tick();
    COMMAND = STR;
    tick();
  endtask

  initial begin
    RST = 1'b1; CAL_VALID = 1'b0; TILT_RAW = 1'b0;
    INITIAL_X = 8'd0; INITIAL_Y = 8'd0; COMMAND = STR;
    DISTANCE_FRONT = 8'd250; DISTANCE_SIDE_FRONT = 8'd50;
    tick(); tick();
    RST = 1'b0;
    chk("rst_ori", 16'(ORIENTATION), 16'd0);
    chk("rst_sector", 16'(SECTOR), 16'd1);
    chk("rst_cal", 16'(CALIBRATED), 16'd0);
    chk("rst_back", 16'(BACK_DISTANCE), 16'd0);
    chk("rst_right", 16'(RIGHT_DISTANCE), 16'd0);
    chk("rst_zone", 16'(ZONE_INDEX), 16'd0);
    chk("rst_hit", 16'(ZONE_HIT), 16'd0);

    COMMAND = RIGHT;
    repeat (5) tick();
    chk("ori_hold_during_turn", 16'(ORIENTATION), 16'd0);
    COMMAND = STR;
    tick();
    chk("ori_right_credit", 16'(ORIENTATION), 16'd1);
    turn(RIGHT); turn(RIGHT); turn(RIGHT);
    chk("ori_wrap_w_to_n", 16'(ORIENTATION), 16'd0);
    for (int i = 0; i < 4; i++) begin
      turn(LEFT);
      chk("ori_left_seq", 16'(ORIENTATION), 16'(3 - i));
    end
    chk("uncal_sector_a", 16'(SECTOR), 16'd1);

    INITIAL_X = 8'd200; INITIAL_Y = 8'd200; CAL_VALID = 1'b1;
    tick();
    CAL_VALID = 1'b0;
    chk("cal_flag", 16'(CALIBRATED), 16'd1);
    tick();
    chk("back_sat_n", 16'(BACK_DISTANCE), 16'd0);
    chk("right_n", 16'(RIGHT_DISTANCE), 16'd150);

    turn(LEFT);
    DISTANCE_FRONT = 8'd114;
    tick();
    chk("a_stay_114", 16'(SECTOR), 16'd1);
    DISTANCE_FRONT = 8'd113;
    tick();
    chk("a_to_b_113", 16'(SECTOR), 16'd2);

    DISTANCE_FRONT = 8'd43;
    tick();
    chk("zone13_idx", 16'(ZONE_INDEX), 16'd13);
    chk("zone13_hit", 16'(ZONE_HIT), 16'd1);
    tick();
    chk("zone13_held_idx", 16'(ZONE_INDEX), 16'd13);
    chk("zone13_no_rehit", 16'(ZONE_HIT), 16'd0);
    DISTANCE_FRONT = 8'd36;
    tick();
    chk("zone14_idx", 16'(ZONE_INDEX), 16'd14);
    chk("zone14_hit", 16'(ZONE_HIT), 16'd1);
    DISTANCE_FRONT = 8'd39;
    tick();
    chk("zone_gap_idx", 16'(ZONE_INDEX), 16'd0);
    chk("zone_gap_hit", 16'(ZONE_HIT), 16'd0);
    chk("back_b_w", 16'(BACK_DISTANCE), 16'd159);
    chk("right_b_w", 16'(RIGHT_DISTANCE), 16'd95);

    DISTANCE_FRONT = 8'd250;
    turn(RIGHT); turn(RIGHT);
    chk("ori_e", 16'(ORIENTATION), 16'd1);
    chk("b_hold_far", 16'(SECTOR), 16'd2);
    DISTANCE_FRONT = 8'd100;
    tick();
    chk("b_to_a", 16'(SECTOR), 16'd1);

    DISTANCE_FRONT = 8'd250;
    turn(LEFT);
    DISTANCE_FRONT = 8'd100;
    tick();
    chk("back_n_100", 16'(BACK_DISTANCE), 16'd100);
    chk("a_to_c", 16'(SECTOR), 16'd3);

    DISTANCE_FRONT = 8'd250;
    turn(LEFT);
    TILT_RAW = 1'b1;
    repeat (3) tick();
    TILT_RAW = 1'b0;
    repeat (3) tick();
    chk("tilt_short_pulse", 16'(SECTOR), 16'd3);
    TILT_RAW = 1'b1;
    repeat (4) tick();
    chk("tilt_edge_latency", 16'(SECTOR), 16'd3);
    tick();
    chk("c_to_d", 16'(SECTOR), 16'd4);

    turn(RIGHT); turn(RIGHT);
    chk("d_hold_e_no_fall", 16'(SECTOR), 16'd4);
    turn(LEFT); turn(LEFT);
    chk("d_ori_w", 16'(ORIENTATION), 16'd3);
    chk("d_hold_w_no_fall", 16'(SECTOR), 16'd4);
    DISTANCE_FRONT = 8'd100;
    tick();
    chk("back_d_w", 16'(BACK_DISTANCE), 16'd98);
    chk("right_d_w", 16'(RIGHT_DISTANCE), 16'd152);

    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("mid_rst_ori", 16'(ORIENTATION), 16'd0);
    chk("mid_rst_sector", 16'(SECTOR), 16'd1);
    chk("mid_rst_cal", 16'(CALIBRATED), 16'd0);
    chk("mid_rst_back", 16'(BACK_DISTANCE), 16'd0);
    chk("mid_rst_right", 16'(RIGHT_DISTANCE), 16'd0);
    chk("mid_rst_zone", 16'(ZONE_INDEX), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
